vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
// Video output scheduler in the pixel_clk domain. Generates horizontal/vertical
// timing (sync, blanking, frame start) for the panel and paces pixel reads from the
// first-word-fall-through (FWFT) clock-crossing pixel FIFO. One read per active pixel.
// Detects FIFO underflow and resynchronises on the next frame boundary.
// PARAMETERS
// HDISP   800  active pixels per line
// HFP     40   horizontal front porch, pixels
// HPULSE  48   hsync width, pixels
// HBP     40   horizontal back porch, pixels
// VDISP   480  active lines per frame
// VFP     13   vertical front porch, lines
// VPULSE  3    vsync width, lines
// VBP     29   vertical back porch, lines
// PORTS
// pixel_clk     in   1   pixel clock, 32 MHz
// sys_rst       in   1   reset, asynchronous, active-high
// enable        in   1   start/stop video; sampled at frame boundary only
// fifo_rdata    in   24  FWFT head word {R,G,B}
// fifo_empty    in   1   FIFO empty
// fifo_rd       out  1   pop head word (combinational)
// vga_hs        out  1   hsync, active-low
// vga_vs        out  1   vsync, active-low
// vga_blank     out  1   1 = outside active area or not streaming
// vga_rgb       out  24  pixel data, zero when blank
// frame_start   out  1   one-cycle pulse when hcnt=0,vcnt=0 and state RUN
// underflow     out  1   sticky underflow flag
// underflow_clr in   1   clears underflow; a set in the same cycle wins
// BEHAVIOUR
// - HTOTAL=HFP+HPULSE+HBP+HDISP (928), VTOTAL=VFP+VPULSE+VBP+VDISP (525).
// - hcnt 0..HTOTAL-1 wraps to 0; vcnt increments on hcnt wrap, wraps at VTOTAL-1.
// - Line layout: [0,HFP) porch, [HFP,HFP+HPULSE) sync, then back porch, display
//   [HTOTAL-HDISP,HTOTAL). Vertical identical using the V parameters.
// - active = h display && v display. Sync asserted while count is in its sync window.
// - All video outputs registered: one cycle latency from counters.
// - Reset/IDLE: hcnt=vcnt=0 held; vga_hs=vga_vs=1, vga_blank=1, vga_rgb=0, fifo_rd=0,
//   frame_start=0; underflow=0 on reset only.
// - FSM states IDLE, WAIT, RUN, RESYNC:
//   IDLE: enable=1 -> WAIT. Counters held.
//   WAIT: counters run, sync generated, blank=1, no reads. Move to RUN at frame
//     boundary (hcnt=HTOTAL-1,vcnt=VTOTAL-1) if enable=1 and fifo_empty=0;
//     enable=0 at boundary -> IDLE.
//   RUN: fifo_rd = active && !fifo_empty. Popped word appears on vga_rgb next cycle
//     with vga_blank=0. active && fifo_empty -> set underflow, output black
//     (blank=0, rgb=0), enter RESYNC. enable=0 only acts at frame boundary: -> IDLE.
//   RESYNC: no reads, blank=1 for the rest of the frame. Boundary rules as WAIT.
// - Every active pixel of a RUN frame consumes exactly one word: HDISP*VDISP reads.
// - Reads never occur outside the active area or outside RUN.
// - sys_rst mid-frame: immediate return to reset values. The FIFO writer flushes on the same reset.
// TESTING
// - Reset, enable=0 for 2000 cycles -> hs=vs=1, blank=1, fifo_rd never 1.
// - enable=1 with FIFO never empty -> hs low 48 cycles per 928-cycle line, vs low for
//   3 lines per 525 lines, exactly 384000 fifo_rd per frame, frame_start every 487200 cycles.
// - Counting ramp data 0,1,2.. -> vga_rgb equals ramp in order, 1 cycle after fifo_rd, no gaps.
// - fifo_empty forced high at pixel 1000 of frame -> underflow=1, that pixel rgb=0,
//   no reads until next boundary, RUN resumes next frame; underflow_clr then clears it.
// - enable dropped mid-frame -> frame completes with reads, then IDLE at boundary.
// - sys_rst asserted mid-line asynchronously -> outputs at reset values immediately,
//   state IDLE, underflow=0.

Source files
------------

// File: rtl/vga_timing_ctrl_if.sv
// Bundle between the video timing controller and its surroundings: the FWFT pixel FIFO,
// the panel outputs and the enable/underflow control.
interface vga_timing_ctrl_if;
  logic        enable;
  logic [23:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_rd;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank;
  logic [23:0] vga_rgb;
  logic        frame_start;
  logic        underflow;
  logic        underflow_clr;

  modport master (
    input  enable, fifo_rdata, fifo_empty, underflow_clr,
    output fifo_rd, vga_hs, vga_vs, vga_blank, vga_rgb, frame_start, underflow
  );

  modport slave (
    output enable, fifo_rdata, fifo_empty, underflow_clr,
    input  fifo_rd, vga_hs, vga_vs, vga_blank, vga_rgb, frame_start, underflow
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// Pixel-clock video scheduler: h/v timing, paced FWFT FIFO reads, sticky underflow with
// resynchronisation at the next frame boundary. Video outputs lag the counters by one cycle.
module vga_timing_ctrl #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic               pixel_clk,
  input  logic               sys_rst,
  vga_timing_ctrl_if.master  bus
);

  localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
  localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_S = HW'(HFP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
  localparam logic [HW-1:0] H_DISP_S = HW'(HTOTAL - HDISP);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_S = VW'(VFP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);
  localparam logic [VW-1:0] V_DISP_S = VW'(VTOTAL - VDISP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN,
    ST_RESYNC
  } state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           blank_q, blank_d;
  logic [23:0]    rgb_q, rgb_d;
  logic           fs_q, fs_d;
  logic           uf_q, uf_d;

  logic h_end, v_end, boundary;
  logic h_act, v_act, active;
  logic h_sync, v_sync;
  logic streaming, rd, uf_set;

  assign h_end     = (hcnt_q == H_LAST);
  assign v_end     = (vcnt_q == V_LAST);
  assign boundary  = h_end && v_end;
  assign h_act     = (hcnt_q >= H_DISP_S);
  assign v_act     = (vcnt_q >= V_DISP_S);
  assign active    = h_act && v_act;
  assign h_sync    = (hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E);
  assign v_sync    = (vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E);
  assign streaming = (state_q == ST_RUN);
  assign rd        = streaming && active && !bus.fifo_empty;
  assign uf_set    = streaming && active && bus.fifo_empty;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    if (state_q == ST_IDLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
      if (bus.enable) state_d = ST_WAIT;
    end else begin
      hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
      if (h_end) vcnt_d = v_end ? '0 : vcnt_q + 1'b1;
      // The boundary decision overrides an underflow on the final pixel: a stream
      // that cannot start (FIFO empty) just idles in WAIT for another frame.
      if (boundary) begin
        if (!bus.enable)         state_d = ST_IDLE;
        else if (!bus.fifo_empty) state_d = ST_RUN;
        else                      state_d = ST_WAIT;
      end else if (uf_set) begin
        state_d = ST_RESYNC;
      end
    end

    hs_d    = (state_q == ST_IDLE) || !h_sync;
    vs_d    = (state_q == ST_IDLE) || !v_sync;
    blank_d = !(streaming && active);
    rgb_d   = rd ? bus.fifo_rdata : '0;
    fs_d    = streaming && (hcnt_q == '0) && (vcnt_q == '0);
    uf_d    = uf_set || (uf_q && !bus.underflow_clr);
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.fifo_rd     = rd;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank   = blank_q;
  assign bus.vga_rgb     = rgb_q;
  assign bus.frame_start = fs_q;
  assign bus.underflow   = uf_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunken 15x8 raster: vector table of timing windows,
// ramp-FIFO scoreboard, and sequences for underflow, enable drop and async reset.
module tb_vga_timing_ctrl;
  localparam int HDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
  localparam int VDISP = 4, VFP = 1, VPULSE = 2, VBP = 1;
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int FRAME  = HTOTAL * VTOTAL;
  localparam int ACTIVE = HDISP * VDISP;

  logic pixel_clk = 1'b0;
  logic sys_rst   = 1'b1;
  vga_timing_ctrl_if vif();

  vga_timing_ctrl #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk(pixel_clk),
    .sys_rst  (sys_rst),
    .bus      (vif)
  );

  always #5 pixel_clk = ~pixel_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FWFT FIFO model: counting ramp, advanced after each pop
  logic [23:0] ramp = 24'h000100;
  assign vif.fifo_rdata = ramp;
  logic [23:0] exp_q[$];
  logic [23:0] exp_word;
  logic        pop_pend = 1'b0;

  always @(negedge pixel_clk) begin
    if (sys_rst) begin
      exp_q.delete();
      pop_pend = 1'b0;
    end else begin
      if (pop_pend) begin
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          chk("sb_rgb", int'(vif.vga_rgb), int'(exp_word));
          chk("sb_blank", int'(vif.vga_blank), 0);
        end
      end
      pop_pend = vif.fifo_rd;
      if (vif.fifo_rd) exp_q.push_back(vif.fifo_rdata);
    end
  end

  always @(posedge pixel_clk) begin
    if (pop_pend && !sys_rst) begin
      #1;
      ramp = ramp + 24'd1;
    end
  end

  typedef struct {
    bit en;
    bit empty;
    bit align;
    int warm;
    int cycles;
    int rd;
    int hs;
    int vs;
    int fs;
    int blk;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    sys_rst = 1'b1;
    vif.enable = 1'b0;
    vif.fifo_empty = 1'b0;
    vif.underflow_clr = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1 sys_rst = 1'b0;
    @(negedge pixel_clk);
  endtask

  task automatic wait_fs(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge pixel_clk);
      if (vif.frame_start) seen = 1'b1;
    end
  endtask

  // Counts output events over n consecutive negedges, starting with the current one
  task automatic measure(input int n, output int rd, output int hs, output int vs,
                         output int fs, output int blk);
    rd = 0; hs = 0; vs = 0; fs = 0; blk = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge pixel_clk);
      if (vif.fifo_rd) rd++;
      if (!vif.vga_hs) hs++;
      if (!vif.vga_vs) vs++;
      if (vif.frame_start) fs++;
      if (!vif.vga_blank) blk++;
    end
  endtask

  int  m_rd, m_hs, m_vs, m_fs, m_blk, n;
  bit  seen;

  initial begin
    vif.enable = 1'b0;
    vif.fifo_empty = 1'b0;
    vif.underflow_clr = 1'b0;

    vecs[0] = '{en:1'b0, empty:1'b0, align:1'b0, warm:0, cycles:2000,
                rd:0, hs:0, vs:0, fs:0, blk:0};
    vecs[1] = '{en:1'b1, empty:1'b0, align:1'b1, warm:0, cycles:3*FRAME,
                rd:3*ACTIVE, hs:3*VTOTAL*HPULSE, vs:3*VPULSE*HTOTAL, fs:3, blk:3*ACTIVE};
    vecs[2] = '{en:1'b1, empty:1'b1, align:1'b0, warm:200, cycles:3*FRAME,
                rd:0, hs:3*VTOTAL*HPULSE, vs:3*VPULSE*HTOTAL, fs:0, blk:0};
    vecs[3] = '{en:1'b1, empty:1'b0, align:1'b1, warm:0, cycles:FRAME,
                rd:ACTIVE, hs:VTOTAL*HPULSE, vs:VPULSE*HTOTAL, fs:1, blk:ACTIVE};
    vecs[4] = '{en:1'b1, empty:1'b0, align:1'b0, warm:5, cycles:100,
                rd:0, hs:-1, vs:-1, fs:0, blk:0};

    @(negedge pixel_clk);
    chk("rst_hs", int'(vif.vga_hs), 1);
    chk("rst_vs", int'(vif.vga_vs), 1);
    chk("rst_blank", int'(vif.vga_blank), 1);
    chk("rst_rgb", int'(vif.vga_rgb), 0);
    chk("rst_fs", int'(vif.frame_start), 0);
    chk("rst_rd", int'(vif.fifo_rd), 0);
    chk("rst_uf", int'(vif.underflow), 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      vif.enable = vecs[v].en;
      vif.fifo_empty = vecs[v].empty;
      if (vecs[v].align) begin
        wait_fs(400, seen);
        chk($sformatf("v%0d_fs_seen", v), int'(seen), 1);
      end else begin
        repeat (vecs[v].warm) @(negedge pixel_clk);
      end
      measure(vecs[v].cycles, m_rd, m_hs, m_vs, m_fs, m_blk);
      chk($sformatf("v%0d_rd", v), m_rd, vecs[v].rd);
      if (vecs[v].hs >= 0) chk($sformatf("v%0d_hs_low", v), m_hs, vecs[v].hs);
      if (vecs[v].vs >= 0) chk($sformatf("v%0d_vs_low", v), m_vs, vecs[v].vs);
      chk($sformatf("v%0d_fs", v), m_fs, vecs[v].fs);
      chk($sformatf("v%0d_blank_low", v), m_blk, vecs[v].blk);
      chk($sformatf("v%0d_uf", v), int'(vif.underflow), 0);
    end

    // Underflow on pixel 10, with a simultaneous clear that must lose
    do_reset();
    vif.enable = 1'b1;
    wait_fs(400, seen);
    chk("uf_fs0", int'(seen), 1);
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      @(negedge pixel_clk);
      if (vif.fifo_rd) n++;
    end
    chk("uf_px_reached", n, 10);
    @(posedge pixel_clk); #1;
    vif.fifo_empty = 1'b1;
    vif.underflow_clr = 1'b1;
    @(negedge pixel_clk);
    chk("uf_no_rd_empty", int'(vif.fifo_rd), 0);
    @(posedge pixel_clk); #1;
    vif.fifo_empty = 1'b0;
    vif.underflow_clr = 1'b0;
    @(negedge pixel_clk);
    chk("uf_set_wins", int'(vif.underflow), 1);
    chk("uf_px_blank", int'(vif.vga_blank), 0);
    chk("uf_px_rgb", int'(vif.vga_rgb), 0);
    @(negedge pixel_clk);
    chk("uf_resync_blank", int'(vif.vga_blank), 1);
    m_rd = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (vif.fifo_rd) m_rd++;
      @(negedge pixel_clk);
      if (vif.frame_start) seen = 1'b1;
    end
    chk("uf_resync_rd", m_rd, 0);
    chk("uf_fs1", int'(seen), 1);
    measure(FRAME, m_rd, m_hs, m_vs, m_fs, m_blk);
    chk("uf_resume_rd", m_rd, ACTIVE);
    chk("uf_resume_blank_low", m_blk, ACTIVE);
    chk("uf_sticky", int'(vif.underflow), 1);
    @(posedge pixel_clk); #1 vif.underflow_clr = 1'b1;
    @(posedge pixel_clk); #1 vif.underflow_clr = 1'b0;
    @(negedge pixel_clk);
    chk("uf_cleared", int'(vif.underflow), 0);

    // Enable dropped early in a RUN frame: the frame completes, then IDLE
    do_reset();
    vif.enable = 1'b1;
    wait_fs(400, seen);
    chk("en_fs", int'(seen), 1);
    m_rd = 0;
    m_fs = 0;
    for (int i = 0; i < 300; i++) begin
      if (i > 0) @(negedge pixel_clk);
      if (vif.fifo_rd) m_rd++;
      if (vif.frame_start) m_fs++;
      if (i == 30) vif.enable = 1'b0;
    end
    chk("en_drop_rd", m_rd, ACTIVE);
    chk("en_drop_fs", m_fs, 1);
    measure(50, m_rd, m_hs, m_vs, m_fs, m_blk);
    chk("idle_hs_low", m_hs, 0);
    chk("idle_vs_low", m_vs, 0);
    chk("idle_blank_low", m_blk, 0);

    // Asynchronous reset while displaying, with underflow already set
    do_reset();
    vif.enable = 1'b1;
    wait_fs(400, seen);
    chk("ar_fs0", int'(seen), 1);
    n = 0;
    for (int i = 0; i < 200 && n == 0; i++) begin
      @(negedge pixel_clk);
      if (vif.fifo_rd) n = 1;
    end
    @(posedge pixel_clk); #1 vif.fifo_empty = 1'b1;
    @(posedge pixel_clk); #1 vif.fifo_empty = 1'b0;
    @(negedge pixel_clk);
    chk("ar_pre_uf", int'(vif.underflow), 1);
    wait_fs(400, seen);
    chk("ar_fs1", int'(seen), 1);
    n = 0;
    for (int i = 0; i < 200 && n == 0; i++) begin
      @(negedge pixel_clk);
      if (!vif.vga_blank) n = 1;
    end
    chk("ar_in_display", n, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("ar_hs", int'(vif.vga_hs), 1);
    chk("ar_vs", int'(vif.vga_vs), 1);
    chk("ar_blank", int'(vif.vga_blank), 1);
    chk("ar_rgb", int'(vif.vga_rgb), 0);
    chk("ar_fs", int'(vif.frame_start), 0);
    chk("ar_rd", int'(vif.fifo_rd), 0);
    chk("ar_uf", int'(vif.underflow), 0);
    vif.enable = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1 sys_rst = 1'b0;
    @(negedge pixel_clk);
    measure(60, m_rd, m_hs, m_vs, m_fs, m_blk);
    chk("ar_idle_rd", m_rd, 0);
    chk("ar_idle_hs_low", m_hs, 0);
    chk("ar_idle_blank_low", m_blk, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
